// File: rtl/fp_modalu_pipe.sv
// Three-stage modular ALU (ADD/SUB/MUL/HALF mod Q) with a valid/ready stream interface.
// MUL is a full product in S1, a Barrett estimate in S2 and a final correction in S3.
module fp_modalu_pipe #(
  parameter int unsigned W     = 23,
  parameter int unsigned Q     = 8380417,
  parameter int unsigned MU    = 8396807,
  parameter int unsigned LANES = 1,
  parameter int unsigned TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [1:0]           i_op,
  input  logic [LANES*W-1:0]   i_a,
  input  logic [LANES*W-1:0]   i_b,
  input  logic [TAG_W-1:0]     i_tag,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [LANES*W-1:0]   o_res,
  output logic [TAG_W-1:0]     o_tag
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;

  localparam int unsigned HQ   = (Q + 1) / 2;
  localparam logic [W-1:0] QV  = Q[W-1:0];
  localparam logic [W:0]   MUV = MU[W:0];
  localparam logic [W-1:0] HQV = HQ[W-1:0];

  logic w_en;

  logic                               r_v1, r_v2, r_v3;
  logic [1:0]                         r_op1, r_op2;
  logic [TAG_W-1:0]                   r_tag1, r_tag2, r_tag3;
  logic [LANES-1:0][2*W-1:0]          r_p1;
  logic [LANES-1:0][W+1:0]            r_r2;
  logic [LANES-1:0][W-1:0]            r_res3;

  logic [LANES-1:0][2*W-1:0]          w_s1;
  logic [LANES-1:0][W+1:0]            w_s2;
  logic [LANES-1:0][W-1:0]            w_s3;

  // Every stage moves together whenever the output slot is empty or being drained.
  assign w_en    = !r_v3 || o_ready;
  assign i_ready = w_en;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [W-1:0]     w_a, w_b;
    logic [W:0]       w_sum, w_dif, w_difq;
    logic [W-1:0]     w_add, w_sub, w_half, w_lin;
    logic [2*W-1:0]   w_mul;
    logic [W:0]       w_ph, w_t;
    logic [2*W+1:0]   w_tm;
    logic [W+1:0]     w_r, w_c1, w_c2;

    assign w_a = i_a[k*W +: W];
    assign w_b = i_b[k*W +: W];

    // S1: linear ops finish here; MUL only forms the full product.
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_add  = (w_sum >= {1'b0, QV}) ? W'(w_sum - {1'b0, QV}) : W'(w_sum);
    assign w_dif  = {1'b0, w_a} - {1'b0, w_b};
    assign w_difq = w_dif + {1'b0, QV};
    assign w_sub  = w_dif[W] ? W'(w_difq) : W'(w_dif);
    assign w_half = {1'b0, w_a[W-1:1]} + (w_a[0] ? HQV : '0);
    assign w_mul  = {{W{1'b0}}, w_a} * {{W{1'b0}}, w_b};

    assign w_lin = (i_op == OP_ADD) ? w_add :
                   (i_op == OP_SUB) ? w_sub : w_half;
    assign w_s1[k] = (i_op == OP_MUL) ? w_mul : {{W{1'b0}}, w_lin};

    // S2: Barrett quotient estimate; the remainder stays below 3Q so W+2 bits suffice.
    assign w_ph = r_p1[k][2*W-1:W-1];
    assign w_tm = {{(W+1){1'b0}}, w_ph} * {{(W+1){1'b0}}, MUV};
    assign w_t  = (W+1)'(w_tm >> (W+1));
    assign w_r  = (W+2)'(r_p1[k]) -
                  (W+2)'({{(W+1){1'b0}}, w_t} * {{(W+2){1'b0}}, QV});

    assign w_s2[k] = (r_op1 == OP_MUL) ? w_r : (W+2)'(r_p1[k][W-1:0]);

    // S3: at most two conditional subtractions bring the remainder into [0,Q).
    assign w_c1 = (r_r2[k] >= {2'b00, QV}) ? (r_r2[k] - {2'b00, QV}) : r_r2[k];
    assign w_c2 = (w_c1 >= {2'b00, QV}) ? (w_c1 - {2'b00, QV}) : w_c1;

    assign w_s3[k] = (r_op2 == OP_MUL) ? W'(w_c2) : W'(r_r2[k]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_op1  <= '0;
      r_op2  <= '0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
      r_p1   <= '0;
      r_r2   <= '0;
      r_res3 <= '0;
    end else if (w_en) begin
      r_v1   <= i_valid;
      r_op1  <= i_op;
      r_tag1 <= i_tag;
      r_p1   <= w_s1;

      r_v2   <= r_v1;
      r_op2  <= r_op1;
      r_tag2 <= r_tag1;
      r_r2   <= w_s2;

      r_v3   <= r_v2;
      r_tag3 <= r_tag2;
      r_res3 <= w_s3;
    end
  end

  assign o_valid = r_v3;
  assign o_tag   = r_tag3;
  assign o_res   = r_res3;

endmodule

// File: tb/tb_fp_modalu_pipe.sv
// Scoreboard bench for fp_modalu_pipe: a 4-lane and a 1-lane instance share one stimulus stream.
// Expected results come from a plain integer mod-Q model and are queued at accept time.
module tb_fp_modalu_pipe;

  localparam int W     = 23;
  localparam int Q     = 8380417;
  localparam int MU    = 8396807;
  localparam int L     = 4;
  localparam int TAG_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             i_valid;
  logic [1:0]       i_op;
  logic [L*W-1:0]   i_a, i_b;
  logic [TAG_W-1:0] i_tag;
  logic             o_ready = 1'b0;

  logic             i_ready4, o_valid4;
  logic [L*W-1:0]   o_res4;
  logic [TAG_W-1:0] o_tag4;
  logic             i_ready1, o_valid1;
  logic [W-1:0]     o_res1;
  logic [TAG_W-1:0] o_tag1;

  fp_modalu_pipe #(.W(W), .Q(Q), .MU(MU), .LANES(L), .TAG_W(TAG_W)) u_dut4 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready4), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .i_tag(i_tag), .o_valid(o_valid4), .o_ready(o_ready),
    .o_res(o_res4), .o_tag(o_tag4));

  fp_modalu_pipe #(.W(W), .Q(Q), .MU(MU), .LANES(1), .TAG_W(TAG_W)) u_dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready1), .i_op(i_op),
    .i_a(i_a[W-1:0]), .i_b(i_b[W-1:0]), .i_tag(i_tag), .o_valid(o_valid1), .o_ready(o_ready),
    .o_res(o_res1), .o_tag(o_tag1));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint unsigned x, y, q, r;
    x = 64'(a);
    y = 64'(b);
    q = 64'(Q);
    case (op)
      2'b00:   r = (x + y) % q;
      2'b01:   r = (x + q - y) % q;
      2'b10:   r = (x * y) % q;
      default: r = (x * ((q + 1) / 2)) % q;
    endcase
    return W'(r);
  endfunction

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [L*W-1:0]   res;
    int               acc;
    bit               lat;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  ready_mode = 1;
  bit  lat_chk = 1'b0;
  bit  hold_prev = 1'b0;
  logic [L*W-1:0]   held_res;
  logic [TAG_W-1:0] held_tag;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       o_ready <= 1'b0;
      1:       o_ready <= 1'b1;
      default: o_ready <= 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops and compares on output transfers, pushes model results on accepts.
  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      chk("i_ready4", 128'(i_ready4), 128'(!o_valid4 || o_ready));
      chk("i_ready1", 128'(i_ready1), 128'(!o_valid1 || o_ready));
      if (hold_prev) begin
        chk("hold_valid", 128'(o_valid4), 128'(1));
        chk("hold_res", 128'(o_res4), 128'(held_res));
        chk("hold_tag", 128'(o_tag4), 128'(held_tag));
      end
      if (o_valid4 && o_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 128'(o_valid4), 128'(0));
        end else begin
          e = sb.pop_front();
          chk("tag4", 128'(o_tag4), 128'(e.tag));
          chk("res4", 128'(o_res4), 128'(e.res));
          chk("valid1", 128'(o_valid1), 128'(1));
          chk("tag1", 128'(o_tag1), 128'(e.tag));
          chk("res1", 128'(o_res1), 128'(e.res[W-1:0]));
          if (e.lat) chk("latency", 128'(cyc - e.acc), 128'(3));
        end
      end else if (o_valid1 && o_ready) begin
        chk("dut1_spurious", 128'(o_valid1), 128'(0));
      end
      hold_prev = o_valid4 && !o_ready;
      held_res  = o_res4;
      held_tag  = o_tag4;
      if (i_valid && i_ready4) begin
        e.tag = i_tag;
        e.acc = cyc;
        e.lat = lat_chk;
        for (int k = 0; k < L; k++)
          e.res[k*W +: W] = model(i_op, i_a[k*W +: W], i_b[k*W +: W]);
        sb.push_back(e);
      end
    end
  end

  function automatic logic [L*W-1:0] rep(input logic [W-1:0] x);
    return {L{x}};
  endfunction

  function automatic logic [L*W-1:0] rnd_vec();
    logic [L*W-1:0] v;
    for (int k = 0; k < L; k++) v[k*W +: W] = W'($urandom_range(0, Q - 1));
    return v;
  endfunction

  task automatic send(input logic [1:0] op, input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                      input logic [TAG_W-1:0] tag);
    int guard;
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_tag   = tag;
    guard   = 0;
    @(negedge clk);
    while (!i_ready4 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("send_timeout", 128'(i_ready4), 128'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int guard;
    i_valid = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) chk("drain_timeout", 128'(sb.size()), 128'(0));
    idle(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b0;
    i_valid = 1'b0;
    i_op    = 2'b00;
    i_a     = '0;
    i_b     = '0;
    i_tag   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid4", 128'(o_valid4), 128'(0));
    chk("rst_res4", 128'(o_res4), 128'(0));
    chk("rst_tag4", 128'(o_tag4), 128'(0));
    chk("rst_valid1", 128'(o_valid1), 128'(0));
    chk("rst_res1", 128'(o_res1), 128'(0));
    chk("rst_iready", 128'(i_ready4), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // Boundary values, each with a 3-cycle latency check.
    lat_chk = 1'b1;
    send(2'b00, rep(W'(8380416)), rep(W'(1)), 8'd1);
    send(2'b00, rep(W'(4190208)), rep(W'(4190208)), 8'd2);
    send(2'b01, rep(W'(0)), rep(W'(1)), 8'd3);
    send(2'b01, rep(W'(5)), rep(W'(5)), 8'd4);
    send(2'b10, rep(W'(8380416)), rep(W'(8380416)), 8'd5);
    send(2'b10, rep(W'(2)), rep(W'(4190209)), 8'd6);
    send(2'b10, rep(W'(0)), rep(W'(1234567)), 8'd7);
    send(2'b11, rep(W'(1)), rep(W'(0)), 8'd8);
    send(2'b11, rep(W'(8380416)), rep(W'(0)), 8'd9);
    send(2'b11, rep(W'(2)), rep(W'(0)), 8'd10);
    send(2'b11, rep(W'(0)), rep(W'(0)), 8'd11);
    drain();

    // Back-to-back mixed stream, distinct lane data.
    for (int i = 0; i < 16; i++) send(2'(i % 4), rnd_vec(), rnd_vec(), 8'(i));
    drain();
    lat_chk = 1'b0;

    // Full pipe under a 5-cycle stall.
    ready_mode = 0;
    idle(1);
    send(2'b00, rnd_vec(), rnd_vec(), 8'h20);
    send(2'b10, rnd_vec(), rnd_vec(), 8'h21);
    send(2'b01, rnd_vec(), rnd_vec(), 8'h22);
    i_valid = 1'b1;
    i_op    = 2'b11;
    i_a     = rnd_vec();
    i_b     = rnd_vec();
    i_tag   = 8'h23;
    repeat (5) begin
      @(negedge clk);
      chk("bp_iready", 128'(i_ready4), 128'(0));
      chk("bp_ovalid", 128'(o_valid4), 128'(1));
    end
    ready_mode = 1;
    @(posedge clk);
    #1;
    send(i_op, i_a, i_b, i_tag);
    drain();

    // Random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      send(2'($urandom_range(0, 3)), rnd_vec(), rnd_vec(), 8'(i));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    ready_mode = 1;
    drain();

    // Random MUL sweep.
    for (int i = 0; i < 10000; i++) send(2'b10, rnd_vec(), rnd_vec(), 8'(i));
    drain();

    // Reset with three results in flight.
    ready_mode = 0;
    idle(1);
    send(2'b00, rnd_vec(), rnd_vec(), 8'hA0);
    send(2'b10, rnd_vec(), rnd_vec(), 8'hA1);
    send(2'b11, rnd_vec(), rnd_vec(), 8'hA2);
    i_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid4", 128'(o_valid4), 128'(0));
    chk("mid_rst_res4", 128'(o_res4), 128'(0));
    chk("mid_rst_tag4", 128'(o_tag4), 128'(0));
    chk("mid_rst_valid1", 128'(o_valid1), 128'(0));
    chk("mid_rst_res1", 128'(o_res1), 128'(0));
    ready_mode = 1;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_quiet", 128'(o_valid4), 128'(0));
    end
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send(2'b10, rnd_vec(), rnd_vec(), 8'h55);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
